itch_feed_arbiter: RTL and testbench



---
 rtl/itch_pkg.sv | 19 +
 rtl/itch_rr_pick.sv | 40 ++++
 rtl/itch_feed_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_itch_feed_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/itch_pkg.sv
// ---------------------------------------------------------------------------
// itch_pkg
// Shared definitions for the ITCH feed arbiter slice.
//   arb_state_t      : arbiter lock state (IDLE, FWD, DRAIN)
//   N_SRC_DEFAULT    : default number of upstream feed sources
//   MAX_GAP_DEFAULT  : default idle-cycle tolerance inside a message
// ---------------------------------------------------------------------------
package itch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FWD   = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    localparam int N_SRC_DEFAULT   = 4;
    localparam int MAX_GAP_DEFAULT = 16;

endpackage

// File: rtl/itch_rr_pick.sv
// ---------------------------------------------------------------------------
// itch_rr_pick
// Combinational round-robin picker: returns the first requesting index at or
// after ptr, wrapping modulo N_SRC.
//   req         in  N_SRC  request vector
//   ptr         in  SRC_W  starting search position
//   grant       out SRC_W  winning index (0 when nothing requests)
//   grant_valid out 1      at least one request present
// ---------------------------------------------------------------------------
module itch_rr_pick
    import itch_pkg::*;
#(
    parameter int N_SRC = N_SRC_DEFAULT,
    localparam int SRC_W = $clog2(N_SRC)
)(
    input  logic [N_SRC-1:0] req,
    input  logic [SRC_W-1:0] ptr,
    output logic [SRC_W-1:0] grant,
    output logic             grant_valid
);

    logic [SRC_W-1:0] idx_s;

    // Rotating priority scan; the first hit from ptr onward is kept.
    always_comb begin
        grant       = {SRC_W{1'b0}};
        grant_valid = 1'b0;
        idx_s       = {SRC_W{1'b0}};
        for (int k = 0; k < N_SRC; k++) begin
            idx_s = SRC_W'((int'(ptr) + k) % N_SRC);
            if (req[idx_s] && !grant_valid) begin
                grant       = idx_s;
                grant_valid = 1'b1;
            end else begin
                grant_valid = grant_valid;
            end
        end
    end

endmodule

// File: rtl/itch_feed_arbiter.sv
// ---------------------------------------------------------------------------
// itch_feed_arbiter
// Shares one ITCH byte-stream parser among N_SRC feed sources. Grants are
// message-atomic and round-robin; stalled or malformed messages are aborted
// and their remainder drained so the parser never sees interleaved bytes.
//   clk, rst         clock, synchronous active-high reset
//   src_valid/start/end/data  per-source byte stream (data byte i = [8i+7:8i])
//   src_ready        per-source accept (combinational from registered state)
//   start_msg/end_msg/message/valid  registered parser stream (1-cycle latency)
//   busy             a message is locked (FWD or DRAIN)
//   cur_src          currently / last granted source
//   abort, abort_src one-cycle abort pulse and source of the last abort
// ---------------------------------------------------------------------------
module itch_feed_arbiter
    import itch_pkg::*;
#(
    parameter int N_SRC   = N_SRC_DEFAULT,
    parameter int MAX_GAP = MAX_GAP_DEFAULT,
    localparam int SRC_W  = $clog2(N_SRC)
)(
    input  logic               clk,
    input  logic               rst,
    input  logic [N_SRC-1:0]   src_valid,
    input  logic [N_SRC-1:0]   src_start,
    input  logic [N_SRC-1:0]   src_end,
    input  logic [8*N_SRC-1:0] src_data,
    output logic [N_SRC-1:0]   src_ready,
    output logic               start_msg,
    output logic               end_msg,
    output logic [7:0]         message,
    output logic               valid,
    output logic               busy,
    output logic [SRC_W-1:0]   cur_src,
    output logic               abort,
    output logic [SRC_W-1:0]   abort_src
);

    localparam int GAP_W = $clog2(MAX_GAP + 1);
    localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(MAX_GAP);
    localparam logic [SRC_W-1:0] LAST_SRC  = SRC_W'(N_SRC - 1);
    localparam logic [N_SRC-1:0] SEL0      = N_SRC'(1);

    // Round-robin successor with wrap for non-power-of-two source counts.
    function automatic logic [SRC_W-1:0] next_ptr(input logic [SRC_W-1:0] p);
        if (p == LAST_SRC) begin
            next_ptr = {SRC_W{1'b0}};
        end else begin
            next_ptr = p + SRC_W'(1);
        end
    endfunction

    arb_state_t        state_r, state_n;
    logic [SRC_W-1:0]  g_r, g_n;
    logic [SRC_W-1:0]  rr_ptr_r, rr_ptr_n;
    logic [GAP_W-1:0]  gap_cnt_r, gap_cnt_n, gap_inc_s;
    logic              valid_r, start_msg_r, end_msg_r, busy_r, abort_r;
    logic [7:0]        message_r;
    logic [SRC_W-1:0]  abort_src_r;

    logic [N_SRC-1:0]  src_ready_s;
    logic              fwd_s, fwd_start_s, fwd_end_s, abort_s;
    logic [7:0]        fwd_data_s;
    logic [SRC_W-1:0]  pick_idx_s;
    logic              pick_valid_s;
    logic              sel_valid_s, sel_start_s, sel_end_s;
    logic [7:0]        sel_data_s, pick_data_s;

    itch_rr_pick #(.N_SRC(N_SRC)) u_pick (
        .req         (src_valid & src_start),
        .ptr         (rr_ptr_r),
        .grant       (pick_idx_s),
        .grant_valid (pick_valid_s)
    );

    // Locked-source and candidate byte views.
    always_comb begin
        sel_valid_s = src_valid[g_r];
        sel_start_s = src_start[g_r];
        sel_end_s   = src_end[g_r];
        sel_data_s  = src_data[{g_r, 3'b000} +: 8];
        pick_data_s = src_data[{pick_idx_s, 3'b000} +: 8];
        gap_inc_s   = (gap_cnt_r >= GAP_LIMIT) ? GAP_LIMIT : gap_cnt_r + GAP_W'(1);
    end

    // Next-state, handshake and forwarding decisions.
    always_comb begin
        state_n     = state_r;
        g_n         = g_r;
        rr_ptr_n    = rr_ptr_r;
        gap_cnt_n   = gap_cnt_r;
        src_ready_s = {N_SRC{1'b0}};
        fwd_s       = 1'b0;
        fwd_start_s = 1'b0;
        fwd_end_s   = 1'b0;
        fwd_data_s  = 8'd0;
        abort_s     = 1'b0;
        case (state_r)
            IDLE: begin
                // Stray mid-message bytes are swallowed; losing starts wait.
                src_ready_s = src_valid & ~src_start;
                if (pick_valid_s) begin
                    src_ready_s[pick_idx_s] = 1'b1;
                    fwd_s       = 1'b1;
                    fwd_start_s = 1'b1;
                    fwd_end_s   = src_end[pick_idx_s];
                    fwd_data_s  = pick_data_s;
                    g_n         = pick_idx_s;
                    if (src_end[pick_idx_s]) begin
                        rr_ptr_n = next_ptr(pick_idx_s);
                    end else begin
                        state_n   = FWD;
                        gap_cnt_n = {GAP_W{1'b0}};
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            FWD: begin
                src_ready_s = SEL0 << g_r;
                if (sel_valid_s) begin
                    // A start inside a message means the previous end was lost.
                    abort_s     = sel_start_s;
                    fwd_s       = 1'b1;
                    fwd_start_s = sel_start_s;
                    fwd_end_s   = sel_end_s;
                    fwd_data_s  = sel_data_s;
                    gap_cnt_n   = {GAP_W{1'b0}};
                    if (sel_end_s) begin
                        state_n  = IDLE;
                        rr_ptr_n = next_ptr(g_r);
                    end else begin
                        state_n = FWD;
                    end
                end else begin
                    gap_cnt_n = gap_inc_s;
                    if (gap_inc_s == GAP_LIMIT) begin
                        abort_s = 1'b1;
                        state_n = DRAIN;
                    end else begin
                        state_n = FWD;
                    end
                end
            end
            DRAIN: begin
                src_ready_s = SEL0 << g_r;
                if (sel_valid_s && sel_start_s) begin
                    // Re-lock on a fresh message from the same source.
                    fwd_s       = 1'b1;
                    fwd_start_s = 1'b1;
                    fwd_end_s   = sel_end_s;
                    fwd_data_s  = sel_data_s;
                    gap_cnt_n   = {GAP_W{1'b0}};
                    if (sel_end_s) begin
                        state_n  = IDLE;
                        rr_ptr_n = next_ptr(g_r);
                    end else begin
                        state_n = FWD;
                    end
                end else if (sel_valid_s && sel_end_s) begin
                    state_n  = IDLE;
                    rr_ptr_n = next_ptr(g_r);
                end else begin
                    state_n = DRAIN;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and registered parser-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            g_r         <= {SRC_W{1'b0}};
            rr_ptr_r    <= {SRC_W{1'b0}};
            gap_cnt_r   <= {GAP_W{1'b0}};
            valid_r     <= 1'b0;
            start_msg_r <= 1'b0;
            end_msg_r   <= 1'b0;
            message_r   <= 8'd0;
            busy_r      <= 1'b0;
            abort_r     <= 1'b0;
            abort_src_r <= {SRC_W{1'b0}};
        end else begin
            state_r     <= state_n;
            g_r         <= g_n;
            rr_ptr_r    <= rr_ptr_n;
            gap_cnt_r   <= gap_cnt_n;
            valid_r     <= fwd_s;
            start_msg_r <= fwd_s & fwd_start_s;
            end_msg_r   <= fwd_s & fwd_end_s;
            message_r   <= fwd_s ? fwd_data_s : 8'd0;
            busy_r      <= (state_n != IDLE);
            abort_r     <= abort_s;
            abort_src_r <= abort_s ? g_r : abort_src_r;
        end
    end

    assign src_ready = src_ready_s;
    assign start_msg = start_msg_r;
    assign end_msg   = end_msg_r;
    assign message   = message_r;
    assign valid     = valid_r;
    assign busy      = busy_r;
    assign cur_src   = g_r;
    assign abort     = abort_r;
    assign abort_src = abort_src_r;

endmodule

// File: tb/tb_itch_feed_arbiter.sv
// ---------------------------------------------------------------------------
// tb_itch_feed_arbiter
// Directed stimulus with a scoreboard: each driven cycle pushes the parser
// word it should produce; a negedge monitor pops and compares on valid/abort.
// ---------------------------------------------------------------------------
module tb_itch_feed_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   src_valid, src_start, src_end, src_ready;
    logic [8*N-1:0] src_data;
    logic           start_msg, end_msg, valid, busy, abort;
    logic [7:0]     message;
    logic [1:0]     cur_src, abort_src;

    int  tests  = 0;
    int  fails  = 0;
    int  cyc    = 0;
    bit  mon_en = 1'b0;

    logic [9:0] exp_q[$];
    int         ab_cyc_q[$];
    logic [1:0] ab_src_q[$];

    itch_feed_arbiter #(.N_SRC(4), .MAX_GAP(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .src_valid (src_valid),
        .src_start (src_start),
        .src_end   (src_end),
        .src_data  (src_data),
        .src_ready (src_ready),
        .start_msg (start_msg),
        .end_msg   (end_msg),
        .message   (message),
        .valid     (valid),
        .busy      (busy),
        .cur_src   (cur_src),
        .abort     (abort),
        .abort_src (abort_src)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] oh(input int s);
        oh = N'(1) << s;
    endfunction

    function automatic logic [7:0] mb(input logic [7:0] t, input int i);
        mb = (i == 0) ? t : 8'(i);
    endfunction

    // Scoreboard monitor: parser stream and abort pulses.
    always @(negedge clk) begin
        if (mon_en) begin
            if (valid) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL mon_unexpected_byte: got 0x%0h, expected no output",
                             {start_msg, end_msg, message});
                end else begin
                    chk("mon_byte", 32'({start_msg, end_msg, message}), 32'(exp_q.pop_front()));
                end
            end else begin
                chk("mon_idle_zero", 32'({start_msg, end_msg, message}), 32'd0);
            end
            if (abort) begin
                if (ab_src_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL mon_unexpected_abort: got src %0d, expected no abort", abort_src);
                end else begin
                    chk("abort_src", 32'(abort_src), 32'(ab_src_q.pop_front()));
                    chk("abort_cycle", 32'(cyc), 32'(ab_cyc_q.pop_front()));
                end
            end
        end
    end

    task automatic drive(input logic [N-1:0] v, input logic [N-1:0] st, input logic [N-1:0] en,
                         input logic [8*N-1:0] d, input logic [N-1:0] exp_rdy,
                         input bit fwd, input logic [9:0] word,
                         input bit ab, input logic [1:0] ab_src, input string tag);
        @(negedge clk);
        src_valid = v;
        src_start = st;
        src_end   = en;
        src_data  = d;
        #1;
        chk({tag, "_ready"}, 32'(src_ready), 32'(exp_rdy));
        if (fwd) exp_q.push_back(word);
        if (ab) begin
            ab_cyc_q.push_back(cyc + 1);
            ab_src_q.push_back(ab_src);
        end
        @(posedge clk);
        #1;
        src_valid = '0;
        src_start = '0;
        src_end   = '0;
        src_data  = '0;
    endtask

    task automatic sb(input int s, input logic st, input logic en, input logic [7:0] d,
                      input bit fwd, input bit ab, input string tag);
        logic [8*N-1:0] dv;
        dv = '0;
        dv[8*s +: 8] = d;
        drive(oh(s), st ? oh(s) : '0, en ? oh(s) : '0, dv, oh(s), fwd, {st, en, d}, ab, 2'(s), tag);
    endtask

    task automatic chk_idle(input string tag, input logic exp_busy, input logic [1:0] exp_cur);
        @(negedge clk);
        chk({tag, "_busy"}, 32'(busy), 32'(exp_busy));
        chk({tag, "_cur_src"}, 32'(cur_src), 32'(exp_cur));
    endtask

    initial begin
        rst = 1'b1;
        src_valid = '0; src_start = '0; src_end = '0; src_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_stream", 32'({start_msg, end_msg, message}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cur_src", 32'(cur_src), 32'd0);
        chk("rst_abort", 32'({abort, abort_src}), 32'd0);
        chk("rst_ready", 32'(src_ready), 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;

        // Contention src0 vs src2 with rr_ptr=0: src0 wins, src2 waits.
        drive(4'b0101, 4'b0101, 4'b0000, {8'h00, 8'h54, 8'h00, 8'h53}, 4'b0001,
              1'b1, {1'b1, 1'b0, 8'h53}, 1'b0, 2'd0, "t2_c1");
        for (int i = 1; i <= 2; i++)
            drive(4'b0101, 4'b0100, (i == 2) ? 4'b0001 : 4'b0000, {8'h00, 8'h54, 8'h00, 8'(i)},
                  4'b0001, 1'b1, {1'b0, (i == 2), 8'(i)}, 1'b0, 2'd0, "t2_src0");
        // rr_ptr=1: src2 now beats a fresh src0 start.
        drive(4'b0101, 4'b0101, 4'b0000, {8'h00, 8'h54, 8'h00, 8'h53}, 4'b0100,
              1'b1, {1'b1, 1'b0, 8'h54}, 1'b0, 2'd0, "t2_c2");
        for (int i = 1; i <= 2; i++)
            drive(4'b0101, 4'b0001, (i == 2) ? 4'b0100 : 4'b0000, {8'h00, 8'(16 + i), 8'h00, 8'h53},
                  4'b0100, 1'b1, {1'b0, (i == 2), 8'(16 + i)}, 1'b0, 2'd0, "t2_src2");
        // Single-byte message from src0 (rr_ptr=3 wraps to 0).
        sb(0, 1'b1, 1'b1, 8'h53, 1'b1, 1'b0, "t2_single");
        chk_idle("t2_done", 1'b0, 2'd0);

        // Stray non-start bytes in IDLE are accepted and dropped.
        sb(2, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0, "t5_stray1");
        sb(2, 1'b0, 1'b1, 8'h78, 1'b0, 1'b0, "t5_stray2");
        drive(4'b0110, 4'b0010, 4'b0010, {8'h00, 8'h79, 8'h5a, 8'h00}, 4'b0110,
              1'b1, {1'b1, 1'b1, 8'h5a}, 1'b0, 2'd0, "t5_mixed");
        chk_idle("t5_done", 1'b0, 2'd1);

        // 36-byte 'A' message from src1, no gaps.
        for (int i = 0; i < 36; i++)
            sb(1, (i == 0), (i == 35), mb(8'h41, i), 1'b1, 1'b0, "t1_A");
        chk_idle("t1_done", 1'b0, 2'd1);

        // src3 'E' stalls 16 cycles after byte 10: abort, then drain.
        for (int i = 0; i <= 10; i++)
            sb(3, (i == 0), 1'b0, mb(8'h45, i), 1'b1, 1'b0, "t3_E");
        for (int k = 1; k <= 16; k++)
            drive(4'b0000, 4'b0000, 4'b0000, '0, 4'b1000, 1'b0, 10'd0, (k == 16), 2'd3, "t3_gap");
        chk_idle("t3_drain", 1'b1, 2'd3);
        for (int i = 11; i <= 14; i++)
            sb(3, 1'b0, (i == 14), mb(8'h45, i), 1'b0, 1'b0, "t3_drain_byte");
        chk_idle("t3_done", 1'b0, 2'd3);
        chk("t3_abort_src_hold", 32'(abort_src), 32'd3);

        // src1 'D' restarts at byte 5: abort, new start forwarded, lock kept.
        for (int i = 0; i <= 4; i++)
            sb(1, (i == 0), 1'b0, mb(8'h44, i), 1'b1, 1'b0, "t4_D");
        sb(1, 1'b1, 1'b0, 8'h44, 1'b1, 1'b1, "t4_restart");
        for (int i = 1; i <= 3; i++)
            sb(1, 1'b0, (i == 3), mb(8'h44, i), 1'b1, 1'b0, "t4_D2");
        chk_idle("t4_done", 1'b0, 2'd1);

        // src3 'U' interrupted by reset at byte 20.
        for (int i = 0; i <= 19; i++)
            sb(3, (i == 0), 1'b0, mb(8'h55, i), 1'b1, 1'b0, "t6_U");
        rst = 1'b1;
        sb(3, 1'b0, 1'b0, 8'd20, 1'b0, 1'b0, "t6_rst_byte");
        rst = 1'b0;
        @(negedge clk);
        chk("t6_rst_valid", 32'(valid), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_cur_src", 32'(cur_src), 32'd0);
        chk("t6_rst_abort", 32'({abort, abort_src}), 32'd0);
        for (int i = 21; i <= 23; i++)
            sb(3, 1'b0, (i == 23), 8'(i), 1'b0, 1'b0, "t6_stray");
        // rr_ptr back at 0: src1 beats src3.
        drive(4'b1010, 4'b1010, 4'b1010, {8'h56, 8'h00, 8'h55, 8'h00}, 4'b0010,
              1'b1, {1'b1, 1'b1, 8'h55}, 1'b0, 2'd0, "t6_contend");
        sb(3, 1'b1, 1'b1, 8'h56, 1'b1, 1'b0, "t6_src3");
        chk_idle("t6_done", 1'b0, 2'd3);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        chk("abort_q_drained", 32'(ab_src_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
